// File: rtl/kernel_reader.sv
// kernel_reader: read-side sequencer for the kernel weight RAM.
// Walks kernel indices base_kernel .. base_kernel+kernel_cnt-1, absorbs the
// RAM's one-cycle read latency and streams each kernel word out over a
// valid/ready interface through a 4-entry output FIFO.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            one-cycle run request (honoured only when idle)
//   base_kernel      first kernel index, sampled on accepted start
//   kernel_cnt       number of kernels to read (0..pKERNEL_NUM)
//   kernel_addr      registered RAM read address
//   kernel_data      RAM read data, valid one cycle after kernel_addr sampled
//   m_valid/m_ready  output stream handshake
//   m_data, m_last   kernel word and final-beat marker
//   busy, done, err  run in progress, end-of-run pulse, range-reject pulse
//
// Build option: define KERNEL_READER_WRAP_EN to wrap indices modulo
// pKERNEL_NUM instead of rejecting ranges that run past the top.
module kernel_reader #(
  parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
  parameter int unsigned pULTRA_RAM_NUM     = 8,
  parameter int unsigned pKERNEL_NUM        = 1024,
  localparam int unsigned AW = $clog2(pKERNEL_NUM),
  localparam int unsigned DW = pWEIGHT_DATA_WIDTH * pULTRA_RAM_NUM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_kernel,
  input  logic [AW:0]   kernel_cnt,
  output logic [AW-1:0] kernel_addr,
  input  logic [DW-1:0] kernel_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;
  localparam int unsigned SW = AW + 2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d, addr_next;
  logic [AW:0]             rem_q, rem_d;
  logic                    iss_q, iss_d, iss_last_q, iss_last_d;
  logic                    ram_q, ram_last_q;
  logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DW-1:0]           mem_q [FIFO_DEPTH];
  logic [DW-1:0]           mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   last_q, last_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    valid_q, mlast_q;
  logic                    pop, can_issue, range_bad;
  logic [OW-1:0]           outstanding;

  assign pop         = valid_q & m_ready;
  // FIFO entries plus reads still in the address and RAM stages
  assign outstanding = {1'b0, count_q} + OW'(iss_q) + OW'(ram_q);
  assign can_issue   = outstanding < OW'(FIFO_DEPTH);
  assign addr_next   = (addr_q == AW'(pKERNEL_NUM - 1)) ? '0 : addr_q + AW'(1);

`ifdef KERNEL_READER_WRAP_EN
  assign range_bad = 1'b0;
`else
  assign range_bad = ({2'b00, base_kernel} + {1'b0, kernel_cnt}) > SW'(pKERNEL_NUM);
`endif

  // Sequencer: next state, address issue and status pulses
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    iss_d      = 1'b0;
    iss_last_d = 1'b0;
    busy_d     = busy_q;
    done_d     = pop & last_q[0];
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (kernel_cnt == '0) begin
            done_d = 1'b1;
          end else if (range_bad) begin
            err_d = 1'b1;
          end else begin
            state_d    = S_FETCH;
            addr_d     = base_kernel;
            rem_d      = kernel_cnt - (AW+1)'(1);
            iss_d      = 1'b1;
            iss_last_d = (kernel_cnt == (AW+1)'(1));
            busy_d     = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (rem_q == '0) begin
          state_d = S_DRAIN;
        end else if (can_issue) begin
          addr_d     = addr_next;
          rem_d      = rem_q - (AW+1)'(1);
          iss_d      = 1'b1;
          iss_last_d = (rem_q == (AW+1)'(1));
          if (rem_q == (AW+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Stays here through the done cycle, so a start then is ignored
        if (count_q == '0 && !iss_q && !ram_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift FIFO: head always in entry 0 so m_data comes straight from a register
  always_comb begin
    mem_d   = mem_q;
    last_d  = last_q;
    count_d = count_q;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        mem_d[i]  = mem_q[i+1];
        last_d[i] = last_q[i+1];
      end
      mem_d[FIFO_DEPTH-1]  = '0;
      last_d[FIFO_DEPTH-1] = 1'b0;
      count_d = count_q - CW'(1);
    end
    if (ram_q) begin
      mem_d[count_d[PW-1:0]]  = kernel_data;
      last_d[count_d[PW-1:0]] = ram_last_q;
      count_d = count_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      iss_q      <= 1'b0;
      iss_last_q <= 1'b0;
      ram_q      <= 1'b0;
      ram_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      last_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      mlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      iss_q      <= iss_d;
      iss_last_q <= iss_last_d;
      ram_q      <= iss_q;
      ram_last_q <= iss_last_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
      last_q     <= last_d;
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      mlast_q    <= (count_d != '0) & last_d[0];
    end
  end

  assign kernel_addr = addr_q;
  assign m_valid     = valid_q;
  assign m_data      = mem_q[0];
  assign m_last      = mlast_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_kernel_reader.sv
// Testbench for kernel_reader: RAM model with one-cycle read latency,
// expected-beat scoreboard checked by a stream monitor, scenario tasks.
module tb_kernel_reader;
  localparam int unsigned WDW = 64;
  localparam int unsigned URN = 8;
  localparam int unsigned KN  = 1024;
  localparam int unsigned DW  = WDW * URN;
  localparam int unsigned AW  = $clog2(KN);

  logic          clk = 1'b0;
  logic          rst, start, m_ready;
  logic [AW-1:0] base_kernel;
  logic [AW:0]   kernel_cnt;
  logic [AW-1:0] kernel_addr;
  logic [DW-1:0] kernel_data;
  logic          m_valid, m_last, busy, done, err;
  logic [DW-1:0] m_data;

  int checks   = 0;
  int failures = 0;
  int beat_cnt = 0;
  logic [DW:0] exp_q[$];

  kernel_reader #(.pWEIGHT_DATA_WIDTH(WDW), .pULTRA_RAM_NUM(URN), .pKERNEL_NUM(KN)) dut (
    .clk(clk), .rst(rst), .start(start), .base_kernel(base_kernel),
    .kernel_cnt(kernel_cnt), .kernel_addr(kernel_addr), .kernel_data(kernel_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_word(input int unsigned a);
    logic [DW-1:0] w;
    for (int i = 0; i < int'(DW / 32); i++)
      w[i*32 +: 32] = (a * 32'h0100_0193) ^ (32'(i) << 24) ^ 32'h5A00_0000;
    return w;
  endfunction

  // Registered-read RAM model
  always @(posedge clk) kernel_data <= ram_word(32'(kernel_addr));

  // Scoreboard monitor: every handshake must match the next expected beat
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      logic [DW:0] e;
      checks++;
      beat_cnt++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got=%0h", {m_last, m_data});
      end else begin
        e = exp_q.pop_front();
        if ({m_last, m_data} !== e) begin
          failures++;
          $display("FAIL beat_data got=%0h want=%0h", {m_last, m_data}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int unsigned base, input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      exp_q.push_back({(k == n - 1) ? 1'b1 : 1'b0, ram_word((base + k) % KN)});
  endtask

  task automatic launch(input int unsigned base, input int unsigned n);
    tick();
    base_kernel = AW'(base);
    kernel_cnt  = (AW+1)'(n);
    start       = 1'b1;
  endtask

  // Runs until done plus a few quiet cycles; mode 0 ready=1, 1 toggle, 2 random
  task automatic run_until_done(input int budget, input int mode, output int ndone);
    int post;
    ndone = 0;
    post  = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      start = 1'b0;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = i[0];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (done) ndone++;
      if (ndone != 0) begin
        post++;
        if (post == 4) break;
      end
    end
    tick();
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_kernel = '0; kernel_cnt = '0; m_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (kernel_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h want=0", kernel_addr); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", m_valid); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", m_last); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_data got=%0h want=0", m_data); end
    checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b want=000", {busy, done, err}); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int nd = 0;
    beat_cnt = 0;
    push_run(5, 4);
    launch(5, 4);
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      @(negedge clk);
      if (c <= 4) begin
        checks++;
        if (kernel_addr !== AW'(4 + c)) begin failures++; $display("FAIL basic_addr c=%0d got=%0d want=%0d", c, kernel_addr, 4 + c); end
      end
      checks++;
      if (m_valid !== ((c >= 3 && c <= 6) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL basic_valid c=%0d got=%b", c, m_valid); end
      checks++;
      if (busy !== ((c <= 7) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL basic_busy c=%0d got=%b", c, busy); end
      if (done) nd++;
      checks++;
      if (done !== ((c == 7) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL basic_done c=%0d got=%b", c, done); end
    end
    checks++; if (beat_cnt != 4 || exp_q.size() != 0 || nd != 1) begin failures++; $display("FAIL basic_count beats=%0d left=%0d dones=%0d want=4,0,1", beat_cnt, exp_q.size(), nd); end
  endtask

  task automatic test_zero();
    launch(7, 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({done, busy, m_valid, err} !== {(c == 1) ? 1'b1 : 1'b0, 3'b000}) begin
        failures++; $display("FAIL zero_cnt c=%0d got done,busy,valid,err=%b", c, {done, busy, m_valid, err});
      end
    end
  endtask

  task automatic test_backpressure();
    int nd;
    beat_cnt = 0;
    push_run(0, 16);
    launch(0, 16);
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      m_ready = 1'b0;
    end
    @(negedge clk);
    checks++; if (kernel_addr !== AW'(3)) begin failures++; $display("FAIL stall_addr got=%0d want=3", kernel_addr); end
    checks++; if (m_valid !== 1'b1 || m_last !== 1'b0 || m_data !== ram_word(0)) begin
      failures++; $display("FAIL stall_head valid=%b last=%b data=%0h", m_valid, m_last, m_data);
    end
    run_until_done(200, 1, nd);
    checks++; if (nd != 1 || beat_cnt != 16 || exp_q.size() != 0) begin failures++; $display("FAIL toggle_run dones=%0d beats=%0d left=%0d want=1,16,0", nd, beat_cnt, exp_q.size()); end
  endtask

  task automatic test_random_ready();
    int nd;
    beat_cnt = 0;
    push_run(300, 20);
    launch(300, 20);
    run_until_done(400, 2, nd);
    checks++; if (nd != 1 || beat_cnt != 20 || exp_q.size() != 0) begin failures++; $display("FAIL random_run dones=%0d beats=%0d left=%0d want=1,20,0", nd, beat_cnt, exp_q.size()); end
  endtask

  task automatic test_range();
    int nd;
    beat_cnt = 0;
`ifdef KERNEL_READER_WRAP_EN
    push_run(1020, 8);
    launch(1020, 8);
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (kernel_addr !== AW'((1019 + c) % KN) || err !== 1'b0) begin
        failures++; $display("FAIL wrap_addr c=%0d got=%0d err=%b want=%0d", c, kernel_addr, err, (1019 + c) % KN);
      end
    end
    run_until_done(100, 0, nd);
    checks++; if (nd != 1 || beat_cnt != 8 || exp_q.size() != 0) begin failures++; $display("FAIL wrap_run dones=%0d beats=%0d want=1,8", nd, beat_cnt); end
`else
    launch(1020, 8);
    nd = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
      @(negedge clk);
      if (done) nd++;
      checks++;
      if (err !== ((c == 1) ? 1'b1 : 1'b0) || busy !== 1'b0 || m_valid !== 1'b0) begin
        failures++; $display("FAIL range_err c=%0d got err,busy,valid=%b", c, {err, busy, m_valid});
      end
    end
    checks++; if (nd != 0 || beat_cnt != 0) begin failures++; $display("FAIL range_quiet dones=%0d beats=%0d want=0,0", nd, beat_cnt); end
`endif
  endtask

  task automatic test_boundary_fit();
    int nd;
    beat_cnt = 0;
    push_run(1020, 4);
    launch(1020, 4);
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL fit_accept got err=%b busy=%b want 0,1", err, busy); end
    run_until_done(100, 0, nd);
    checks++; if (nd != 1 || beat_cnt != 4 || exp_q.size() != 0) begin failures++; $display("FAIL fit_run dones=%0d beats=%0d want=1,4", nd, beat_cnt); end
  endtask

  task automatic test_back_to_back();
    int nd = 0;
    beat_cnt = 0;
    push_run(100, 6);
    launch(100, 6);
    for (int c = 1; c <= 60; c++) begin
      tick();
      start = (c == 2);
      if (c == 2) begin base_kernel = AW'(500); kernel_cnt = (AW+1)'(3); end
      @(negedge clk);
      if (done) begin nd++; break; end
    end
    checks++; if (nd != 1 || beat_cnt != 6 || exp_q.size() != 0) begin failures++; $display("FAIL fetch_start dones=%0d beats=%0d want=1,6", nd, beat_cnt); end
    // start in the done cycle must be ignored
    start = 1'b1; base_kernel = AW'(50); kernel_cnt = (AW+1)'(1);
    tick();
    beat_cnt = 0;
    push_run(60, 2);
    base_kernel = AW'(60); kernel_cnt = (AW+1)'(2);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL done_cycle_start busy=%b done=%b want 0,0", busy, done); end
    run_until_done(100, 0, nd);
    checks++; if (nd != 1 || beat_cnt != 2 || exp_q.size() != 0) begin failures++; $display("FAIL after_done_run dones=%0d beats=%0d want=1,2", nd, beat_cnt); end
  endtask

  task automatic test_reset_mid();
    int nd;
    push_run(0, 10);
    launch(0, 10);
    m_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL midrun_pre valid=%b busy=%b want 1,1", m_valid, busy); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({kernel_addr, m_valid, m_last, busy, done, err} !== '0 || m_data !== '0) begin
      failures++; $display("FAIL midrun_reset addr=%0d valid=%b last=%b busy=%b done=%b err=%b", kernel_addr, m_valid, m_last, busy, done, err);
    end
    exp_q.delete();
    beat_cnt = 0;
    m_ready = 1'b1;
    push_run(2, 2);
    base_kernel = AW'(2); kernel_cnt = (AW+1)'(2); start = 1'b1;
    run_until_done(100, 0, nd);
    checks++; if (nd != 1 || beat_cnt != 2 || exp_q.size() != 0) begin failures++; $display("FAIL post_reset_run dones=%0d beats=%0d want=1,2", nd, beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_random_ready();
    test_range();
    test_boundary_fit();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_reader.md
# kernel_reader

Read-side sequencer for the kernel weight RAM. On `start` it walks a contiguous range of kernel indices, drives `kernel_addr`, absorbs the RAM's one-cycle registered read latency, and delivers each `pWEIGHT_DATA_WIDTH*pULTRA_RAM_NUM`-bit kernel word to the convolution engine over a valid/ready stream. A 4-entry output FIFO sustains one beat per cycle under backpressure.

## Interface
- `pWEIGHT_DATA_WIDTH`, 64, bits per RAM bank word
- `pULTRA_RAM_NUM`, 8, number of banks; kernel word width = product of the two
- `pKERNEL_NUM`, 1024, kernel depth per bank; `AW = $clog2(pKERNEL_NUM)`
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; accepted only in IDLE
- `base_kernel`  in  AW  first kernel index, sampled on accepted `start`
- `kernel_cnt`  in  AW+1  kernels to read (0..pKERNEL_NUM), sampled on accepted `start`
- `kernel_addr`  out  AW  registered read address to kernel RAM
- `kernel_data`  in  pWEIGHT_DATA_WIDTH*pULTRA_RAM_NUM  RAM read data, valid 1 cycle after `kernel_addr` is sampled
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  consumer ready
- `m_data`  out  pWEIGHT_DATA_WIDTH*pULTRA_RAM_NUM  kernel word
- `m_last`  out  1  high on final beat of the run
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run
- `err`  out  1  one-cycle pulse: range rejected (see Configuration)

## Operation
- FSM: IDLE -> FETCH on accepted `start` with `kernel_cnt != 0`; FETCH -> DRAIN when last address issued; DRAIN -> IDLE when FIFO empty and no read in flight.
- `start` with `kernel_cnt == 0`: stay IDLE, pulse `done` next cycle, no beats.
- `start` while not IDLE: ignored, no side effects.
- Issue rule: in FETCH, issue next address when FIFO occupancy + reads in flight (max 2: address stage, RAM stage) < 4. Not issuing holds `kernel_addr`.
- Addresses: `base_kernel`, `base_kernel+1`, …, `base_kernel+kernel_cnt-1`; AW-bit arithmetic, width-checked against macro rule below.
- Each RAM return is pushed into the FIFO; `m_data` is the FIFO head; pop on `m_valid && m_ready`.
- `m_last` asserted with beat number `kernel_cnt-1` only; `m_data`/`m_last` stable while `m_valid && !m_ready`.
- `busy` high from cycle after accepted `start` through the `done` cycle.
- System requirement: RAM `wr_en` must be low while `busy`; reader does not arbitrate.
- Reset values: `kernel_addr`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `done`=0, `err`=0, FIFO empty, FSM IDLE.
- `rst` mid-run: run aborted, FIFO and in-flight reads discarded, no `done`, outputs to reset values next cycle.

## Timing
- Cycle 0 `start` accepted; cycle 1 `kernel_addr`=base, `busy`=1; cycle 2 RAM data; cycle 3 first `m_valid`. Latency start->first beat = 3 cycles.
- With `m_ready` held high: one beat per cycle, N beats occupy cycles 3..N+2.
- `done` pulses the cycle after the handshake of the `m_last` beat; next `start` accepted in that same `done` cycle is ignored (FSM leaves DRAIN only then), accepted from the following cycle.
- Backpressure: at most 4 beats buffered; no beat lost or duplicated regardless of `m_ready` pattern.

## Configuration
- `KERNEL_READER_WRAP_EN` defined: indices computed modulo pKERNEL_NUM; range crossing the top wraps to 0; `err` never asserted.
- Undefined: if `base_kernel + kernel_cnt > pKERNEL_NUM`, `start` is rejected: stay IDLE, pulse `err` next cycle, no `done`, no beats.

## Test plan
- Base 5, cnt 4, `m_ready`=1 -> `kernel_addr` 5,6,7,8 from cycle 1; beats = RAM[5..8] cycles 3..6; `m_last` on beat 4; `done` cycle 7.
- Base 0, cnt 16, `m_ready` toggling 1/0 -> 16 beats in order, none dropped, `kernel_addr` stalls when FIFO+in-flight = 4.
- cnt 0 -> `done` pulse at cycle 1, `m_valid` never high, `busy` stays 0.
- Base 1020, cnt 8 (pKERNEL_NUM=1024): macro on -> addresses 1020..1023,0..3; macro off -> `err` cycle 1, no beats.
- `rst` asserted at beat 3 of a 10-beat run with `m_ready`=0 -> next cycle all outputs at reset values; subsequent run base 2 cnt 2 returns RAM[2],RAM[3] only.
- `start` pulsed during FETCH -> ignored; original run completes with correct count and single `done`.
